pipeline_sr_ce: RTL and testbench

PIPELINE_SR_CE -- requirements
Module: pipeline_sr_ce

---
 rtl/opl3_pkg.sv | 9 +
 rtl/pipeline_fill_counter.sv | 52 +++++
 rtl/pipeline_sr_ce.sv | 76 +++++++
 tb/tb_pipeline_sr_ce.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared opl3 package: width helper used to size pipeline occupancy counters.
package opl3_pkg;

  // Bits needed to hold a count in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_fill_counter.sv
// Occupancy counter for pipeline_sr_ce; logic is present only when
// PIPELINE_SR_CE_FILL_CNT_EN is defined, otherwise count is tied to zero.
module pipeline_fill_counter
  import opl3_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        advance,
  input  logic                        flush,
  input  logic                        inc,
  input  logic                        dec,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned CW = cnt_width(DEPTH);

`ifdef PIPELINE_SR_CE_FILL_CNT_EN
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (advance) begin
      // Entering and leaving in the same advance cancel out.
      case ({inc, dec})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;
`else
  logic w_unused;
  assign w_unused = ^{clk, reset_n, advance, flush, inc, dec};
  assign count    = '0;
`endif

endmodule

// File: rtl/pipeline_sr_ce.sv
// Clock-enabled shift-register pipeline with valid bits, flush and tapped outputs.
// fill_cnt is live only when PIPELINE_SR_CE_FILL_CNT_EN is defined.
module pipeline_sr_ce
  import opl3_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 1,
  parameter int                     STARTING_CYCLE = 1,
  parameter int                     ENDING_CYCLE   = 1,
  parameter logic [DATA_WIDTH-1:0]  POR_VALUE      = '0
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  clk_en,
  input  logic                                                  flush,
  input  logic [DATA_WIDTH-1:0]                                 in,
  input  logic                                                  in_valid,
  output logic [(ENDING_CYCLE-STARTING_CYCLE+1)*DATA_WIDTH-1:0] out,
  output logic [ENDING_CYCLE-STARTING_CYCLE:0]                  out_valid,
  output logic                                                  primed,
  output logic [cnt_width(ENDING_CYCLE)-1:0]                    fill_cnt
);

  localparam int NTAPS = ENDING_CYCLE - STARTING_CYCLE + 1;

  if (STARTING_CYCLE < 1) begin : g_bad_start
    $error("pipeline_sr_ce: STARTING_CYCLE must be >= 1");
  end
  if (ENDING_CYCLE < STARTING_CYCLE) begin : g_bad_end
    $error("pipeline_sr_ce: ENDING_CYCLE must be >= STARTING_CYCLE");
  end

  logic [DATA_WIDTH-1:0] r_data [1:ENDING_CYCLE];
  logic [ENDING_CYCLE:1] r_valid;

  // Flush wins over clk_en; data shifts independent of valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= ENDING_CYCLE; k++) begin
        r_data[k] <= POR_VALUE;
      end
      r_valid <= '0;
    end else if (flush) begin
      for (int k = 1; k <= ENDING_CYCLE; k++) begin
        r_data[k] <= POR_VALUE;
      end
      r_valid <= '0;
    end else if (clk_en) begin
      r_data[1]  <= in;
      r_valid[1] <= in_valid;
      for (int k = 2; k <= ENDING_CYCLE; k++) begin
        r_data[k]  <= r_data[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  for (genvar t = 0; t < NTAPS; t++) begin : g_tap
    assign out[t*DATA_WIDTH +: DATA_WIDTH] = r_data[STARTING_CYCLE+t];
    assign out_valid[t]                    = r_valid[STARTING_CYCLE+t];
  end

  assign primed = r_valid[ENDING_CYCLE];

  pipeline_fill_counter #(
    .DEPTH(ENDING_CYCLE)
  ) u_fill_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .advance(clk_en),
    .flush  (flush),
    .inc    (in_valid),
    .dec    (r_valid[ENDING_CYCLE]),
    .count  (fill_cnt)
  );

endmodule

// File: tb/tb_pipeline_sr_ce.sv
// Scoreboard bench for pipeline_sr_ce (DATA_WIDTH=8, taps 2..4, POR_VALUE=0x3C).
module tb_pipeline_sr_ce;

  localparam logic [7:0] POR = 8'h3C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        flush;
  logic [7:0]  din;
  logic        in_valid;
  logic [23:0] dout;
  logic [2:0]  out_valid;
  logic        primed;
  logic [2:0]  fill_cnt;

  always #5 clk = ~clk;

  pipeline_sr_ce #(
    .DATA_WIDTH    (8),
    .STARTING_CYCLE(2),
    .ENDING_CYCLE  (4),
    .POR_VALUE     (POR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .flush    (flush),
    .in       (din),
    .in_valid (in_valid),
    .out      (dout),
    .out_valid(out_valid),
    .primed   (primed),
    .fill_cnt (fill_cnt)
  );

  typedef struct {
    logic [23:0] out;
    logic [2:0]  ov;
    logic        pr;
    logic [2:0]  fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] m_d [1:4];
  logic       m_v [1:4];
  int         m_cnt;

  function automatic logic [2:0] exp_fc(input int c);
`ifdef PIPELINE_SR_CE_FILL_CNT_EN
    return 3'(c);
`else
    return 3'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 1; k <= 4; k++) begin
      m_d[k] = POR;
      m_v[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic step(input bit en, input bit fl, input logic [7:0] d, input bit v);
    exp_t e;
    @(negedge clk);
    clk_en = en; flush = fl; din = d; in_valid = v;
    @(posedge clk);
    if (fl) begin
      m_reset();
    end else if (en) begin
      m_cnt = m_cnt + int'(v) - int'(m_v[4]);
      for (int k = 4; k >= 2; k--) begin
        m_d[k] = m_d[k-1];
        m_v[k] = m_v[k-1];
      end
      m_d[1] = d;
      m_v[1] = v;
    end
    e.out = {m_d[4], m_d[3], m_d[2]};
    e.ov  = {m_v[4], m_v[3], m_v[2]};
    e.pr  = m_v[4];
    e.fc  = exp_fc(m_cnt);
    q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare at the negedge after each push.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_out", 32'(dout), 32'(e.out));
        chk("sb_out_valid", 32'(out_valid), 32'(e.ov));
        chk("sb_primed", 32'(primed), 32'(e.pr));
        chk("sb_fill_cnt", 32'(fill_cnt), 32'(e.fc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fc_tab [8];
    fc_tab = '{1, 2, 3, 4, 4, 4, 3, 2};
    reset_n = 1'b0; clk_en = 1'b0; flush = 1'b0; din = 8'h00; in_valid = 1'b0;
    m_reset();
    #12;
    chk("rst_out", 32'(dout), 32'h003C3C3C);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_fill", 32'(fill_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Latency: taps 2 and 4
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h22, 1);
    #1 chk("lat_tap2_e2", 32'(dout[7:0]), 32'h11);
    step(1, 0, 8'h33, 1);
    step(1, 0, 8'h44, 0);
    #1 chk("lat_taps_e4", 32'(dout), 32'h112233);
    chk("lat_primed_e4", 32'(primed), 32'd1);
    chk("lat_valid_e4", 32'(out_valid), 32'b111);

    // Gating: enables 1,0,0,1
    step(0, 1, 8'h00, 0);
    step(1, 0, 8'hA5, 1);
    #1 chk("gate_tap2_e1", 32'(out_valid[0]), 32'd0);
    step(0, 0, 8'h5A, 1);
    step(0, 0, 8'h66, 1);
    #1 chk("gate_hold", 32'(dout[7:0]), 32'(POR));
    step(1, 0, 8'h77, 0);
    #1 chk("gate_tap2_e4", 32'(dout[7:0]), 32'hA5);
    chk("gate_valid_e4", 32'(out_valid), 32'b001);

    // Occupancy: 6 valid, 2 invalid (data still moves)
    step(0, 1, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(8'h80 + i), i < 6);
      #1 chk($sformatf("occ_fill_%0d", i), 32'(fill_cnt), 32'(exp_fc(fc_tab[i])));
    end

    // Flush priority from full pipeline
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hC0 + i), 1);
    #1 chk("full_fill", 32'(fill_cnt), 32'(exp_fc(4)));
    step(1, 1, 8'hFF, 1);
    #1 chk("flush_out", 32'(dout), 32'h3C3C3C);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_fill", 32'(fill_cnt), 32'd0);

    // Async reset between edges, no clock needed
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hD0 + i), 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    clk_en = 1'b0;
    #1 chk("arst_out", 32'(dout), 32'h3C3C3C);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_primed", 32'(primed), 32'd0);
    chk("arst_fill", 32'(fill_cnt), 32'd0);
    #2 reset_n = 1'b1;
    m_reset();
    step(1, 0, 8'h77, 1);
    step(1, 0, 8'h88, 1);
    #1 chk("resume_tap2", 32'(dout[7:0]), 32'h77);

    // Mixed pattern
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           8'($urandom), ($urandom_range(0, 1) == 1));
    end

    step(0, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
